mux_nx1_stream: RTL and testbench

Parametrised N-input, W-bit registered stream multiplexer. It is the sequential successor of the 2:1 cell mux. It arbitrates among N valid/ready channels, either by an external select or round-robin, and locks the grant for a whole packet, up to the beat marked LAST. The output is a registered stage with backpressure. It sits between datapath producers and a single shared consumer, and replaces hand-built trees of 2:1 mux cells wherever channels must be shared over time.

---
 rtl/mux_stream_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mux_nx1_stream.sv | 131 +++++++++++++
 tb/tb_mux_nx1_stream.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// Shared types and constants for the packet-locked stream multiplexer.
package mux_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [SW:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (SW + 1)'(k);
            if (idx >= (SW + 1)'(N)) begin
                idx = idx - (SW + 1)'(N);
            end
            if (req[idx[SW-1:0]]) begin
                gnt_idx = idx[SW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-input registered stream mux; grant is held for a whole packet up to LAST.
module mux_nx1_stream
    import mux_stream_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int SW   = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RSTB,
    input  logic [N*W-1:0] IN_DATA,
    input  logic [N-1:0]   IN_VALID,
    input  logic [N-1:0]   IN_LAST,
    output logic [N-1:0]   IN_READY,
    input  logic [SW-1:0]  S,
    output logic [W-1:0]   Q,
    output logic           Q_VALID,
    output logic           Q_LAST,
    input  logic           Q_READY,
    output logic [SW-1:0]  GRANT,
    output logic           BUSY
);

    state_e        state_q, state_d;
    logic [SW-1:0] grant_q, grant_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  q_q, q_d;
    logic          q_valid_q, q_valid_d;
    logic          q_last_q, q_last_d;

    logic          load_en;
    logic          xfer;
    logic          sel_req;
    logic [SW-1:0] arb_idx;
    logic          arb_any;
    logic [W-1:0]  sel_data;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (IN_VALID),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign load_en  = !q_valid_q || Q_READY;
    assign sel_data = IN_DATA[int'(grant_q)*W +: W];
    assign xfer     = (state_q == LOCKED) && load_en && IN_VALID[grant_q];

    // Out-of-range selects simply never match a channel.
    always_comb begin
        sel_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (S == SW'(i) && IN_VALID[i]) begin
                sel_req = 1'b1;
            end
        end
    end

    always_comb begin
        IN_READY = '0;
        if (state_q == LOCKED) begin
            IN_READY[grant_q] = load_en;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        q_last_d  = q_last_q;
        if (q_valid_q && Q_READY) begin
            q_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (MODE == MODE_RR) begin
                    if (arb_any) begin
                        grant_d = arb_idx;
                        state_d = LOCKED;
                    end
                end else if (sel_req) begin
                    grant_d = S;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    q_d       = sel_data;
                    q_last_d  = IN_LAST[grant_q];
                    q_valid_d = 1'b1;
                    if (IN_LAST[grant_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = (int'(grant_q) == N - 1) ? '0 : grant_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = q_valid_q;
    assign Q_LAST  = q_last_q;
    assign GRANT   = grant_q;
    assign BUSY    = (state_q == LOCKED);

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: select-mode, round-robin, wrap and randomized packets.
module tb_mux_nx1_stream;

    typedef struct packed {
        logic       first;
        logic       l;
        logic [7:0] d;
    } beat_t;

    logic CLK = 1'b0;
    logic RSTB = 1'b1;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // N=3 select-mode instance
    logic [23:0] m0_data;
    logic [2:0]  m0_valid, m0_last, m0_ready;
    logic [1:0]  m0_s, m0_grant;
    logic [7:0]  m0_q;
    logic        m0_qv, m0_ql, m0_qr, m0_busy;
    // N=4 round-robin instance
    logic [31:0] r4_data;
    logic [3:0]  r4_valid, r4_last, r4_ready;
    logic [1:0]  r4_s, r4_grant;
    logic [7:0]  r4_q;
    logic        r4_qv, r4_ql, r4_qr, r4_busy;
    // N=3 round-robin instance
    logic [23:0] r3_data;
    logic [2:0]  r3_valid, r3_last, r3_ready;
    logic [1:0]  r3_s, r3_grant;
    logic [7:0]  r3_q;
    logic        r3_qv, r3_ql, r3_qr, r3_busy;

    mux_nx1_stream #(.N(3), .W(8), .MODE(0)) u_m0 (
        .CLK(CLK), .RSTB(RSTB), .IN_DATA(m0_data), .IN_VALID(m0_valid),
        .IN_LAST(m0_last), .IN_READY(m0_ready), .S(m0_s), .Q(m0_q),
        .Q_VALID(m0_qv), .Q_LAST(m0_ql), .Q_READY(m0_qr),
        .GRANT(m0_grant), .BUSY(m0_busy));

    mux_nx1_stream #(.N(4), .W(8), .MODE(1)) u_r4 (
        .CLK(CLK), .RSTB(RSTB), .IN_DATA(r4_data), .IN_VALID(r4_valid),
        .IN_LAST(r4_last), .IN_READY(r4_ready), .S(r4_s), .Q(r4_q),
        .Q_VALID(r4_qv), .Q_LAST(r4_ql), .Q_READY(r4_qr),
        .GRANT(r4_grant), .BUSY(r4_busy));

    mux_nx1_stream #(.N(3), .W(8), .MODE(1)) u_r3 (
        .CLK(CLK), .RSTB(RSTB), .IN_DATA(r3_data), .IN_VALID(r3_valid),
        .IN_LAST(r3_last), .IN_READY(r3_ready), .S(r3_s), .Q(r3_q),
        .Q_VALID(r3_qv), .Q_LAST(r3_ql), .Q_READY(r3_qr),
        .GRANT(r3_grant), .BUSY(r3_busy));

    // Per-cycle observation log of the select-mode driver
    logic [3:0] lg_rdy[64];
    logic       lg_qv[64];
    logic [7:0] lg_q[64];
    logic       lg_ql[64];
    logic       lg_busy[64];
    logic [1:0] lg_grant[64];
    logic [8:0] acc_q[$];

    beat_t src[4][$];
    beat_t exp_q[$];

    task automatic clear_inputs();
        m0_data = '0; m0_valid = '0; m0_last = '0; m0_s = '0; m0_qr = 1'b1;
        r4_data = '0; r4_valid = '0; r4_last = '0; r4_s = '0; r4_qr = 1'b1;
        r3_data = '0; r3_valid = '0; r3_last = '0; r3_s = '0; r3_qr = 1'b1;
    endtask

    task automatic do_reset();
        RSTB = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1 RSTB = 1'b1;
    endtask

    // Drives one packet on channel ch of the select-mode instance and logs outputs.
    task automatic m0_run(input int ch, input int len, input logic [7:0] base,
                          input int cycles, input int bp0, input int bpn,
                          input bit noise);
        int idx;
        bit hs;
        idx = 0;
        acc_q.delete();
        for (int c = 0; c < cycles; c++) begin
            m0_valid = '0;
            m0_last  = '0;
            m0_data  = '0;
            m0_s     = (noise && c > 0) ? 2'($urandom_range(0, 3)) : 2'(ch);
            if (idx < len) begin
                if (noise) begin
                    m0_valid = '1;
                    m0_data  = {3{8'hEE}};
                end
                m0_valid[ch]       = 1'b1;
                m0_data[ch*8 +: 8] = base + 8'(idx);
                m0_last[ch]        = (idx == len - 1);
            end
            m0_qr = !(c >= bp0 && c < bp0 + bpn);
            #1;
            hs = m0_valid[ch] && m0_ready[ch];
            lg_rdy[c] = {1'b0, m0_ready};
            if (m0_qv && m0_qr) acc_q.push_back({m0_ql, m0_q});
            @(posedge CLK);
            #1;
            if (hs) idx++;
            lg_qv[c]    = m0_qv;
            lg_q[c]     = m0_q;
            lg_ql[c]    = m0_ql;
            lg_busy[c]  = m0_busy;
            lg_grant[c] = m0_grant;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 RSTB = 1'b0;
        #1;
        n_cmp++;
        if ({m0_qv, m0_ql, m0_q, m0_busy, m0_grant, m0_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_m0: got %h expected 0",
                     {m0_qv, m0_ql, m0_q, m0_busy, m0_grant, m0_ready});
        end
        n_cmp++;
        if ({r4_qv, r4_ql, r4_q, r4_busy, r4_grant, r4_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_r4: got %h expected 0",
                     {r4_qv, r4_ql, r4_q, r4_busy, r4_grant, r4_ready});
        end
        repeat (2) @(posedge CLK);
        #1 RSTB = 1'b1;
    endtask

    task automatic test_mode0_packet();
        m0_run(2, 3, 8'hA1, 8, 99, 0, 1'b0);
        n_cmp++;
        if ({lg_busy[0], lg_grant[0], lg_qv[0]} !== {1'b1, 2'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL m0_grant_cycle: got %b expected 1100",
                     {lg_busy[0], lg_grant[0], lg_qv[0]});
        end
        n_cmp++;
        if (lg_rdy[0] !== 4'b0000 || lg_rdy[1] !== 4'b0100) begin
            n_bad++;
            $display("FAIL m0_ready: got %b/%b expected 0000/0100", lg_rdy[0], lg_rdy[1]);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({lg_qv[1+i], lg_ql[1+i], lg_q[1+i]} !== {1'b1, i == 2, 8'hA1 + 8'(i)}) begin
                n_bad++;
                $display("FAIL m0_beat%0d: got %b/%b/%h expected 1/%0d/%h", i,
                         lg_qv[1+i], lg_ql[1+i], lg_q[1+i], i == 2, 8'hA1 + 8'(i));
            end
        end
        n_cmp++;
        if (lg_busy[3] !== 1'b0 || lg_qv[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL m0_end: got busy %b qv %b expected 0 0", lg_busy[3], lg_qv[4]);
        end
    endtask

    task automatic test_backpressure();
        m0_run(1, 6, 8'h30, 16, 4, 3, 1'b0);
        for (int c = 4; c < 7; c++) begin
            n_cmp++;
            if ({lg_rdy[c], lg_qv[c], lg_q[c]} !== {4'b0000, 1'b1, 8'h32}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got rdy %b qv %b q %h expected 0000 1 32",
                         c, lg_rdy[c], lg_qv[c], lg_q[c]);
            end
        end
        n_cmp++;
        if (acc_q.size() != 6) begin
            n_bad++;
            $display("FAIL bp_count: got %0d expected 6", acc_q.size());
        end
        for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
            n_cmp++;
            if (acc_q[i] !== {i == 5, 8'h30 + 8'(i)}) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got %h expected %h", i, acc_q[i],
                         {i == 5, 8'h30 + 8'(i)});
            end
        end
    endtask

    task automatic test_sel_hold();
        int nbusy;
        nbusy = 0;
        m0_run(1, 4, 8'h40, 12, 99, 0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (lg_busy[c]) begin
                nbusy++;
                n_cmp++;
                if (lg_grant[c] !== 2'd1) begin
                    n_bad++;
                    $display("FAIL hold_grant%0d: got %0d expected 1", c, lg_grant[c]);
                end
            end
        end
        n_cmp++;
        if (nbusy != 4 || lg_busy[11] !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_busy: got %0d cycles end %b expected 4 0", nbusy, lg_busy[11]);
        end
        n_cmp++;
        if (acc_q.size() != 4) begin
            n_bad++;
            $display("FAIL hold_count: got %0d expected 4", acc_q.size());
        end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            n_cmp++;
            if (acc_q[i] !== {i == 3, 8'h40 + 8'(i)}) begin
                n_bad++;
                $display("FAIL hold_beat%0d: got %h expected %h", i, acc_q[i],
                         {i == 3, 8'h40 + 8'(i)});
            end
        end
    endtask

    task automatic test_invalid_sel();
        m0_s = 2'd3;
        m0_valid = '1;
        m0_last = '1;
        m0_data = 24'h030201;
        m0_qr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if (m0_busy !== 1'b0 || m0_ready !== 3'b000) begin
                n_bad++;
                $display("FAIL bad_sel%0d: got busy %b rdy %b expected 0 000", c, m0_busy, m0_ready);
            end
        end
        m0_valid = '0;
        m0_run(0, 1, 8'h55, 5, 99, 0, 1'b0);
        n_cmp++;
        if (lg_grant[0] !== 2'd0 || lg_busy[0] !== 1'b1 || lg_busy[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL sel0_grant: got %0d %b%b expected 0 10",
                     lg_grant[0], lg_busy[0], lg_busy[1]);
        end
        n_cmp++;
        if (acc_q.size() != 1 || acc_q[0] !== {1'b1, 8'h55}) begin
            n_bad++;
            $display("FAIL sel0_beat: got %0d beats expected 1 of 155", acc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        r4_valid = 4'b0010;
        r4_last = '0;
        r4_data = 32'h0000_2100;
        r4_qr = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        n_cmp++;
        if ({r4_qv, r4_busy, r4_grant, r4_q} !== {1'b1, 1'b1, 2'd1, 8'h21}) begin
            n_bad++;
            $display("FAIL pre_reset: got %b%b %0d %h expected 11 1 21",
                     r4_qv, r4_busy, r4_grant, r4_q);
        end
        #3 RSTB = 1'b0;
        #1;
        n_cmp++;
        if ({r4_qv, r4_ql, r4_q, r4_busy, r4_grant, r4_ready} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected 0",
                     {r4_qv, r4_ql, r4_q, r4_busy, r4_grant, r4_ready});
        end
        r4_valid = '0;
        @(posedge CLK);
        #1 RSTB = 1'b1;
    endtask

    task automatic test_rr_all_valid();
        r4_valid = '1;
        r4_last = '1;
        r4_data = 32'h1312_1110;
        r4_qr = 1'b1;
        acc_q.delete();
        for (int c = 0; c < 10; c++) begin
            #1;
            if (r4_qv && r4_qr) acc_q.push_back({r4_ql, r4_q});
            @(posedge CLK);
            #1;
            n_cmp++;
            if (r4_busy !== (c % 2 == 0)) begin
                n_bad++;
                $display("FAIL rr_bubble%0d: got %b expected %0d", c, r4_busy, c % 2 == 0);
            end
            if (c % 2 == 0) begin
                n_cmp++;
                if (r4_grant !== 2'((c / 2) % 4)) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: got %0d expected %0d", c, r4_grant, (c / 2) % 4);
                end
            end
        end
        n_cmp++;
        if (acc_q.size() < 4) begin
            n_bad++;
            $display("FAIL rr_count: got %0d expected >=4", acc_q.size());
        end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            n_cmp++;
            if (acc_q[i] !== {1'b1, 8'h10 + 8'(i)}) begin
                n_bad++;
                $display("FAIL rr_beat%0d: got %h expected %h", i, acc_q[i], {1'b1, 8'h10 + 8'(i)});
            end
        end
    endtask

    task automatic test_rr_wrap();
        logic [2:0] pat[5] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b101};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            r3_valid = pat[c];
            r3_last = '1;
            r3_data = 24'h727170;
            r3_qr = 1'b1;
            @(posedge CLK);
            #1;
            lg_busy[c]  = r3_busy;
            lg_grant[c] = r3_grant;
            lg_qv[c]    = r3_qv;
            lg_q[c]     = r3_q;
            lg_ql[c]    = r3_ql;
        end
        r3_valid = '0;
        n_cmp++;
        if ({lg_busy[0], lg_grant[0]} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL wrap_g2: got %b %0d expected 1 2", lg_busy[0], lg_grant[0]);
        end
        n_cmp++;
        if ({lg_busy[1], lg_qv[1], lg_ql[1], lg_q[1]} !== {1'b0, 1'b1, 1'b1, 8'h72}) begin
            n_bad++;
            $display("FAIL wrap_beat: got %b%b%b %h expected 011 72",
                     lg_busy[1], lg_qv[1], lg_ql[1], lg_q[1]);
        end
        n_cmp++;
        if ({lg_busy[2], lg_grant[2]} !== {1'b1, 2'd1}) begin
            n_bad++;
            $display("FAIL wrap_ptr0: got %b %0d expected 1 1", lg_busy[2], lg_grant[2]);
        end
        n_cmp++;
        if ({lg_busy[4], lg_grant[4]} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL wrap_ptr2: got %b %0d expected 1 2", lg_busy[4], lg_grant[4]);
        end
    endtask

    task automatic test_rr_random();
        int pos[4];
        int mpos[4];
        bit hs[4];
        int nout, ptr, cyc, np, len;
        bit hold;
        logic [8:0] held;
        beat_t b;
        do_reset();
        exp_q.delete();
        for (int ch = 0; ch < 4; ch++) begin
            src[ch].delete();
            pos[ch] = 0;
            mpos[ch] = 0;
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    b.first = (i == 0);
                    b.l = (i == len - 1);
                    b.d = 8'($urandom);
                    src[ch].push_back(b);
                end
            end
        end
        // Packet-level model: whole packets in round-robin order over non-empty channels
        ptr = 0;
        for (int g = 0; g < 64; g++) begin
            int sel;
            sel = -1;
            for (int k = 0; k < 4; k++) begin
                if (sel < 0 && mpos[(ptr + k) % 4] < src[(ptr + k) % 4].size())
                    sel = (ptr + k) % 4;
            end
            if (sel < 0) break;
            do begin
                b = src[sel][mpos[sel]];
                mpos[sel]++;
                exp_q.push_back(b);
            end while (!b.l);
            ptr = (sel + 1) % 4;
        end
        nout = 0;
        cyc = 0;
        hold = 0;
        held = '0;
        while (nout < exp_q.size() && cyc < 3000) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (pos[ch] < src[ch].size()) begin
                    b = src[ch][pos[ch]];
                    r4_valid[ch] = b.first || ($urandom_range(0, 3) != 0);
                    r4_last[ch] = b.l;
                    r4_data[ch*8 +: 8] = b.d;
                end else begin
                    r4_valid[ch] = 1'b0;
                    r4_last[ch] = 1'b0;
                end
            end
            r4_qr = ($urandom_range(0, 9) < 7);
            #1;
            n_cmp++;
            if ($countones(r4_ready) > 1 || (!r4_busy && r4_ready != 4'b0)) begin
                n_bad++;
                $display("FAIL rnd_ready: got %b busy %b at cycle %0d", r4_ready, r4_busy, cyc);
            end
            if (hold) begin
                n_cmp++;
                if ({r4_qv, r4_ql, r4_q} !== {1'b1, held}) begin
                    n_bad++;
                    $display("FAIL rnd_stable: got %b %h expected 1 %h", r4_qv, {r4_ql, r4_q}, held);
                end
            end
            if (r4_qv && r4_qr) begin
                n_cmp++;
                if ({r4_ql, r4_q} !== {exp_q[nout].l, exp_q[nout].d}) begin
                    n_bad++;
                    $display("FAIL rnd_beat%0d: got %h expected %h", nout, {r4_ql, r4_q},
                             {exp_q[nout].l, exp_q[nout].d});
                end
                nout++;
            end
            hold = r4_qv && !r4_qr;
            held = {r4_ql, r4_q};
            for (int ch = 0; ch < 4; ch++) hs[ch] = r4_valid[ch] && r4_ready[ch];
            @(posedge CLK);
            #1;
            for (int ch = 0; ch < 4; ch++) if (hs[ch]) pos[ch]++;
            cyc++;
        end
        n_cmp++;
        if (nout != exp_q.size()) begin
            n_bad++;
            $display("FAIL rnd_timeout: got %0d beats expected %0d", nout, exp_q.size());
        end
        r4_valid = '0;
    endtask

    initial begin
        test_reset();
        test_mode0_packet();
        test_backpressure();
        test_sel_hold();
        test_invalid_sel();
        test_reset_mid();
        test_rr_all_valid();
        test_rr_wrap();
        test_rr_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
